// File: rtl/z80_call_ret_sequencer.sv
// Post-M1 machine-cycle sequencer for Z80 CALL nn / CALL cc,nn / RET / RET cc.
// Runs the operand reads, stack pushes or pops, and reports new IP, SP and T-state count.
module z80_call_ret_sequencer #(
    parameter int PUSH_EXTRA_T = 1,
    parameter bit WAIT_EN      = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [2:0]  cond_i,
    input  logic [7:0]  reg_f_i,
    input  logic [15:0] reg_ip_i,
    input  logic [15:0] reg_sp_i,
    output logic        bus_mreq_o,
    output logic        bus_rd_o,
    output logic        bus_wr_o,
    output logic [15:0] bus_addr_o,
    output logic [7:0]  bus_wdata_o,
    input  logic        bus_wait_i,
    input  logic [7:0]  bus_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        taken_o,
    output logic [15:0] ip_out_o,
    output logic [15:0] sp_out_o,
    output logic [7:0]  tcount_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_LO, S_RD_HI, S_XT, S_WR_HI, S_WR_LO, S_POP_LO, S_POP_HI, S_FIN
    } state_t;

    typedef enum logic [1:0] {T1, T2, T3, TW} tph_t;

    localparam logic [7:0] XT_LAST = 8'((PUSH_EXTRA_T > 0) ? PUSH_EXTRA_T - 1 : 0);

    state_t      state_q, state_d;
    tph_t        tph_q, tph_d;
    logic [7:0]  xcnt_q, xcnt_d;
    logic [15:0] ip_q, ip_d;
    logic [15:0] sp_q, sp_d;
    logic        taken_q, taken_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [15:0] ipo_q, ipo_d;
    logic [15:0] spo_q, spo_d;

    logic        start_met;
    logic [7:0]  tcnt_inc;
    logic [15:0] ret_addr;

    // Flag select by cc[2:1]: Z, C, P/V, S; condition holds when the flag equals cc[0].
    always_comb begin
        start_met = 1'b0;
        case (cond_i[2:1])
            2'd0: start_met = (reg_f_i[6] == cond_i[0]);
            2'd1: start_met = (reg_f_i[0] == cond_i[0]);
            2'd2: start_met = (reg_f_i[2] == cond_i[0]);
            default: start_met = (reg_f_i[7] == cond_i[0]);
        endcase
    end

    assign tcnt_inc = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
    assign ret_addr = ip_q + 16'd3;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            tph_q   <= T1;
            xcnt_q  <= 8'd0;
            ip_q    <= 16'd0;
            sp_q    <= 16'd0;
            taken_q <= 1'b0;
            lo_q    <= 8'd0;
            hi_q    <= 8'd0;
            tcnt_q  <= 8'd0;
            ipo_q   <= 16'd0;
            spo_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            tph_q   <= tph_d;
            xcnt_q  <= xcnt_d;
            ip_q    <= ip_d;
            sp_q    <= sp_d;
            taken_q <= taken_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            tcnt_q  <= tcnt_d;
            ipo_q   <= ipo_d;
            spo_q   <= spo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tph_d   = tph_q;
        xcnt_d  = xcnt_q;
        ip_d    = ip_q;
        sp_d    = sp_q;
        taken_d = taken_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        tcnt_d  = tcnt_q;
        ipo_d   = ipo_q;
        spo_d   = spo_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ip_d    = reg_ip_i;
                    sp_d    = reg_sp_i;
                    tcnt_d  = 8'd0;
                    tph_d   = T1;
                    xcnt_d  = 8'd0;
                    taken_d = op_i[0] ? start_met : 1'b1;
                    if (!op_i[1]) begin
                        state_d = S_RD_LO;
                    end else if (!op_i[0] || start_met) begin
                        state_d = S_POP_LO;
                    end else begin
                        // Untaken RET cc completes without touching the bus.
                        state_d = S_FIN;
                        ipo_d   = reg_ip_i + 16'd1;
                        spo_d   = reg_sp_i;
                    end
                end
            end

            S_XT: begin
                tcnt_d = tcnt_inc;
                if (xcnt_q == XT_LAST) begin
                    state_d = S_WR_HI;
                end else begin
                    xcnt_d = xcnt_q + 8'd1;
                end
            end

            S_FIN: state_d = S_IDLE;

            default: begin
                tcnt_d = tcnt_inc;
                case (tph_q)
                    T1: tph_d = T2;
                    T2, TW: tph_d = (WAIT_EN && bus_wait_i) ? TW : T3;
                    default: begin
                        tph_d = T1;
                        case (state_q)
                            S_RD_LO: begin
                                lo_d    = bus_rdata_i;
                                state_d = S_RD_HI;
                            end
                            S_RD_HI: begin
                                hi_d = bus_rdata_i;
                                if (taken_q) begin
                                    xcnt_d  = 8'd0;
                                    state_d = (PUSH_EXTRA_T > 0) ? S_XT : S_WR_HI;
                                end else begin
                                    state_d = S_FIN;
                                    ipo_d   = ip_q + 16'd3;
                                    spo_d   = sp_q;
                                end
                            end
                            S_WR_HI: state_d = S_WR_LO;
                            S_WR_LO: begin
                                state_d = S_FIN;
                                ipo_d   = {hi_q, lo_q};
                                spo_d   = sp_q - 16'd2;
                            end
                            S_POP_LO: begin
                                lo_d    = bus_rdata_i;
                                state_d = S_POP_HI;
                            end
                            default: begin
                                state_d = S_FIN;
                                ipo_d   = {bus_rdata_i, lo_q};
                                spo_d   = sp_q + 16'd2;
                            end
                        endcase
                    end
                endcase
            end
        endcase
    end

    // Bus outputs decode from registered state only, so they hold across T1..T3 and Tw.
    always_comb begin
        bus_mreq_o  = 1'b0;
        bus_rd_o    = 1'b0;
        bus_wr_o    = 1'b0;
        bus_addr_o  = 16'd0;
        bus_wdata_o = 8'd0;
        case (state_q)
            S_RD_LO: begin
                bus_mreq_o = 1'b1;
                bus_rd_o   = 1'b1;
                bus_addr_o = ip_q + 16'd1;
            end
            S_RD_HI: begin
                bus_mreq_o = 1'b1;
                bus_rd_o   = 1'b1;
                bus_addr_o = ip_q + 16'd2;
            end
            S_WR_HI: begin
                bus_mreq_o  = 1'b1;
                bus_wr_o    = 1'b1;
                bus_addr_o  = sp_q - 16'd1;
                bus_wdata_o = ret_addr[15:8];
            end
            S_WR_LO: begin
                bus_mreq_o  = 1'b1;
                bus_wr_o    = 1'b1;
                bus_addr_o  = sp_q - 16'd2;
                bus_wdata_o = ret_addr[7:0];
            end
            S_POP_LO: begin
                bus_mreq_o = 1'b1;
                bus_rd_o   = 1'b1;
                bus_addr_o = sp_q;
            end
            S_POP_HI: begin
                bus_mreq_o = 1'b1;
                bus_rd_o   = 1'b1;
                bus_addr_o = sp_q + 16'd1;
            end
            default: ;
        endcase
    end

    assign busy_o   = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done_o   = (state_q == S_FIN);
    assign taken_o  = taken_q;
    assign ip_out_o = ipo_q;
    assign sp_out_o = spo_q;
    assign tcount_o = tcnt_q;

endmodule

// File: tb/tb_z80_call_ret_sequencer.sv
// Scoreboard bench for z80_call_ret_sequencer: a reference model queues expected results
// and bus cycles; a monitor drives WAIT, serves memory and checks each completed sequence.
module tb_z80_call_ret_sequencer;

    localparam int PX = 1;

    typedef struct {
        logic [15:0] ip;
        logic [15:0] sp;
        logic        tk;
        logic [7:0]  tc;
        int          issue;
        int          nops;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          len;
    } op_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [2:0]  cond = 3'd0;
    logic [7:0]  reg_f = 8'd0;
    logic [15:0] reg_ip = 16'd0;
    logic [15:0] reg_sp = 16'd0;
    logic        mreq, rd, wr, busy, done, taken;
    logic [15:0] addr, ip_out, sp_out;
    logic [7:0]  wdata, rdata, tcount;
    logic        bus_wait = 1'b0;

    logic [7:0]  mem [0:65535];
    assign rdata = mem[addr];

    exp_t exp_q[$];
    op_t  eop_q[$];
    op_t  obs_q[$];
    int   wq[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    z80_call_ret_sequencer #(.PUSH_EXTRA_T(PX), .WAIT_EN(1'b1)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .op_i(op), .cond_i(cond),
        .reg_f_i(reg_f), .reg_ip_i(reg_ip), .reg_sp_i(reg_sp),
        .bus_mreq_o(mreq), .bus_rd_o(rd), .bus_wr_o(wr), .bus_addr_o(addr),
        .bus_wdata_o(wdata), .bus_wait_i(bus_wait), .bus_rdata_i(rdata),
        .busy_o(busy), .done_o(done), .taken_o(taken),
        .ip_out_o(ip_out), .sp_out_o(sp_out), .tcount_o(tcount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic flag(input string nm);
        miscompares++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Monitor / memory responder / scoreboard checker.
    initial begin : monitor
        op_t  cur;
        logic cur_act;
        int   cur_n;
        logic newc;
        cur_act = 1'b0;
        cur_n = 0;
        cur = '{wr: 1'b0, addr: 16'd0, data: 8'd0, len: 0};
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                obs_q.delete();
                cur_act = 1'b0;
                bus_wait = 1'b0;
            end else begin
                newc = mreq && (!cur_act || addr != cur.addr || wr != cur.wr);
                if (cur_act && (!mreq || newc)) begin
                    obs_q.push_back(cur);
                    cur_act = 1'b0;
                end
                if (newc) begin
                    cur = '{wr: wr, addr: addr, data: wdata, len: 1};
                    cur_act = 1'b1;
                    cur_n = (wq.size() > 0) ? wq.pop_front() : 0;
                end else if (mreq) begin
                    cur.len++;
                    if (wdata != cur.data) flag("wdata not held through bus cycle");
                end
                bus_wait = mreq && (cur.len >= 2) && (cur.len < 2 + cur_n);
                if (mreq && wr) mem[addr] = wdata;
                if (rd && wr) flag("bus_rd and bus_wr both high");
                if (mreq && !busy) flag("bus_mreq while not busy");
                if (done) begin
                    if (exp_q.size() == 0) begin
                        flag("unexpected done pulse");
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("ip_out", ip_out, e.ip);
                        chk("sp_out", sp_out, e.sp);
                        chk("taken", taken, e.tk);
                        chk("tcount", tcount, e.tc);
                        chk("done latency", cyc - e.issue, e.tc + 1);
                        chk("bus cycle count", obs_q.size(), e.nops);
                        for (int i = 0; i < e.nops; i++) begin
                            op_t x, o;
                            if (eop_q.size() == 0) break;
                            x = eop_q.pop_front();
                            if (obs_q.size() == 0) begin
                                flag("missing bus cycle");
                            end else begin
                                o = obs_q.pop_front();
                                chk("cycle addr", o.addr, x.addr);
                                chk("cycle is write", o.wr, x.wr);
                                chk("cycle length", o.len, x.len);
                                if (x.wr) chk("write data", o.data, x.data);
                            end
                        end
                        obs_q.delete();
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start = 1'b0;
        exp_q.delete();
        eop_q.delete();
        wq.delete();
        @(negedge clk);
        chk("outputs zero in reset",
            {mreq, rd, wr, addr, wdata, busy, done, taken, ip_out, sp_out, tcount}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || done) && n < 100);
        if (busy || done) begin
            flag("timeout waiting for idle");
            do_reset();
            @(negedge clk);
        end
    endtask

    // Reference model: results and bus cycles derived from the instruction semantics.
    task automatic issue(input logic [1:0] o, input logic [2:0] cc, input logic [7:0] f,
                         input logic [15:0] ip, input logic [15:0] sp,
                         input int w0, input int w1, input int w2, input int w3);
        exp_t e;
        op_t  ops[$];
        int   w[4];
        int   fidx[4];
        int   total;
        logic [15:0] ret;
        logic [15:0] a;
        wait_idle();
        fidx = '{6, 0, 2, 7};
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++)
            if (w[i] < 0) w[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        e.tk = o[0] ? (f[fidx[cc[2:1]]] == cc[0]) : 1'b1;
        ret = ip + 16'd3;
        if (!o[1]) begin
            a = ip + 16'd1; ops.push_back('{1'b0, a, mem[a], 0});
            a = ip + 16'd2; ops.push_back('{1'b0, a, mem[a], 0});
            if (e.tk) begin
                a = sp - 16'd1; ops.push_back('{1'b1, a, ret[15:8], 0});
                a = sp - 16'd2; ops.push_back('{1'b1, a, ret[7:0], 0});
                a = ip + 16'd2; e.ip = {mem[a], mem[ip + 16'd1]};
                e.sp = sp - 16'd2;
            end else begin
                e.ip = ret;
                e.sp = sp;
            end
        end else if (e.tk) begin
            a = sp + 16'd1;
            ops.push_back('{1'b0, sp, mem[sp], 0});
            ops.push_back('{1'b0, a, mem[a], 0});
            e.ip = {mem[a], mem[sp]};
            e.sp = sp + 16'd2;
        end else begin
            e.ip = ip + 16'd1;
            e.sp = sp;
        end
        total = (!o[1] && e.tk) ? PX : 0;
        for (int i = 0; i < ops.size(); i++) begin
            ops[i].len = 3 + w[i];
            total += ops[i].len;
            eop_q.push_back(ops[i]);
            wq.push_back(w[i]);
        end
        e.tc = (total > 255) ? 8'hFF : 8'(total);
        e.nops = ops.size();
        start = 1'b1; op = o; cond = cc; reg_f = f; reg_ip = ip; reg_sp = sp;
        e.issue = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for the scoreboard to drain, pulsing start while busy to check it is ignored.
    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            start = busy && ($urandom_range(0, 7) == 0);
            if (start) begin
                op = 2'($urandom); cond = 3'($urandom); reg_f = 8'($urandom);
                reg_ip = 16'($urandom); reg_sp = 16'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            flag("timeout waiting for done");
            do_reset();
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [2:0] cc, input logic [7:0] f,
                       input logic [15:0] ip, input logic [15:0] sp,
                       input int w0, input int w1, input int w2, input int w3);
        issue(o, cc, f, ip, sp, w0, w1, w2, w3);
        wait_done();
    endtask

    initial begin : stim
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        do_reset();

        mem[16'h1001] = 8'h34;
        mem[16'h1002] = 8'h12;
        run(2'd0, 3'd0, 8'h00, 16'h1000, 16'h2000, 0, 0, 0, 0);
        chk("mem[1FFF] pushed ret hi", mem[16'h1FFF], 8'h10);
        chk("mem[1FFE] pushed ret lo", mem[16'h1FFE], 8'h03);

        run(2'd1, 3'd0, 8'h40, 16'h1000, 16'h2000, 0, 0, 0, 0);

        mem[16'hFFFF] = 8'h78;
        mem[16'h0000] = 8'h56;
        run(2'd2, 3'd0, 8'h00, 16'h4000, 16'hFFFF, 0, 0, 0, 0);

        run(2'd0, 3'd0, 8'h00, 16'h1000, 16'h2000, 0, 0, 2, 0);

        run(2'd3, 3'd3, 8'h00, 16'h3000, 16'h2000, 0, 0, 0, 0);

        // Abort mid-push, then confirm a clean following sequence.
        issue(2'd0, 3'd0, 8'h00, 16'h1000, 16'h2000, 0, 0, 0, 0);
        n = 0;
        while (!(wr && addr == 16'h1FFF) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(wr && addr == 16'h1FFF)) flag("timeout waiting for WR_HI");
        do_reset();
        run(2'd0, 3'd0, 8'h00, 16'h1000, 16'h2000, 0, 0, 0, 0);

        for (int i = 0; i < 200; i++)
            run(2'($urandom), 3'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
                -1, -1, -1, -1);

        wait_idle();
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) flag("sequences left unchecked");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
